// File: rtl/uart_word_serializer.sv
// uart_word_serializer
//   Word-to-byte bridge between the datapath and the UART byte FIFOs.
//   TX: latches an NBYTES*DBIT-bit word and writes it one byte per cycle into
//       the transmit FIFO, stalling while the FIFO is full. A held level
//       request sends the word exactly once.
//   RX: packs consecutive received bytes back into a word.
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   wr_word, word_in     : level send request and the word to send
//   fifo_full            : TX FIFO full flag (back-pressure, same-cycle)
//   fifo_wdata, fifo_wr  : byte and write strobe to the TX FIFO
//   busy, done           : busy while sending; one-cycle pulse after last byte
//   rx_byte, rx_valid    : received byte and its one-cycle qualifier
//   rx_word, rx_word_valid : last assembled word and its update pulse
module uart_word_serializer #(
  parameter int DBIT      = 8,
  parameter int NBYTES    = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_word,
  input  logic [NBYTES*DBIT-1:0] word_in,
  input  logic                   fifo_full,
  output logic [DBIT-1:0]        fifo_wdata,
  output logic                   fifo_wr,
  output logic                   busy,
  output logic                   done,
  input  logic [DBIT-1:0]        rx_byte,
  input  logic                   rx_valid,
  output logic [NBYTES*DBIT-1:0] rx_word,
  output logic                   rx_word_valid
);

  localparam int W  = NBYTES * DBIT;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE, HOLD} tx_state_e;

  // ---------------------------------------------------------------- TX side
  tx_state_e       state_q, state_d;
  logic [W-1:0]    tx_sr_q, tx_sr_d;
  logic [CW-1:0]   tx_cnt_q, tx_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      tx_sr_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      tx_sr_q  <= tx_sr_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    fifo_wr    = (state_q == SEND) && !fifo_full;
    fifo_wdata = (MSB_FIRST != 0) ? tx_sr_q[W-1 -: DBIT] : tx_sr_q[DBIT-1:0];
    busy       = (state_q == SEND);
    done       = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (wr_word) begin
          state_d  = SEND;
          tx_sr_d  = word_in;
          tx_cnt_d = '0;
        end
      end
      SEND: begin
        if (fifo_wr) begin
          tx_sr_d = (MSB_FIRST != 0) ? (tx_sr_q << DBIT) : (tx_sr_q >> DBIT);
          // Count saturates at the last byte; the FSM leaves SEND instead.
          if (tx_cnt_q == LAST) state_d = DONE;
          else                  tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      DONE: state_d = wr_word ? HOLD : IDLE;
      HOLD: if (!wr_word) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- RX side
  logic [W-1:0]  rx_asm_q, rx_asm_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [W-1:0]  rx_word_q, rx_word_d;
  logic          rx_wv_q, rx_wv_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_asm_q  <= '0;
      rx_cnt_q  <= '0;
      rx_word_q <= '0;
      rx_wv_q   <= 1'b0;
    end else begin
      rx_asm_q  <= rx_asm_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_word_q <= rx_word_d;
      rx_wv_q   <= rx_wv_d;
    end
  end

  always_comb begin
    rx_asm_d  = rx_asm_q;
    rx_cnt_d  = rx_cnt_q;
    rx_word_d = rx_word_q;
    rx_wv_d   = 1'b0;
    if (rx_valid) begin
      // LSB-first: new byte enters at the top so the first byte ends lowest.
      if (MSB_FIRST != 0)
        rx_asm_d = (rx_asm_q << DBIT) | W'(rx_byte);
      else
        rx_asm_d = (rx_asm_q >> DBIT) | (W'(rx_byte) << (W - DBIT));
      if (rx_cnt_q == LAST) begin
        rx_cnt_d  = '0;
        rx_word_d = rx_asm_d;
        rx_wv_d   = 1'b1;
      end else begin
        rx_cnt_d = rx_cnt_q + CW'(1);
      end
    end
  end

  assign rx_word       = rx_word_q;
  assign rx_word_valid = rx_wv_q;

endmodule

// File: tb/tb_uart_word_serializer.sv
module tb_uart_word_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // DUT A: defaults (16-bit word, LSB first)
  logic        wr_a, full_a, fwr_a, busy_a, done_a, rxv_a, rxwv_a;
  logic [15:0] win_a, rxw_a;
  logic [7:0]  wd_a, rxb_a;

  // DUT B: 32-bit word, MSB first
  logic        wr_b, full_b, fwr_b, busy_b, done_b, rxv_b, rxwv_b;
  logic [31:0] win_b, rxw_b;
  logic [7:0]  wd_b, rxb_b;

  uart_word_serializer dut_a (
    .clk(clk), .reset(reset), .wr_word(wr_a), .word_in(win_a),
    .fifo_full(full_a), .fifo_wdata(wd_a), .fifo_wr(fwr_a),
    .busy(busy_a), .done(done_a), .rx_byte(rxb_a), .rx_valid(rxv_a),
    .rx_word(rxw_a), .rx_word_valid(rxwv_a)
  );

  uart_word_serializer #(.DBIT(8), .NBYTES(4), .MSB_FIRST(1)) dut_b (
    .clk(clk), .reset(reset), .wr_word(wr_b), .word_in(win_b),
    .fifo_full(full_b), .fifo_wdata(wd_b), .fifo_wr(fwr_b),
    .busy(busy_b), .done(done_b), .rx_byte(rxb_b), .rx_valid(rxv_b),
    .rx_word(rxw_b), .rx_word_valid(rxwv_b)
  );

  int compared = 0;
  int mismatched = 0;
  int writes_a = 0, writes_b = 0, dones_a = 0, dones_b = 0;
  logic [7:0]  txq_a[$];
  logic [7:0]  txq_b[$];
  logic [15:0] rxq_a[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  // Scoreboard: pops expected bytes/words as the DUTs produce them.
  always @(negedge clk) begin
    if (fwr_a) begin
      writes_a++;
      if (txq_a.size() == 0) fail_now("tx_a_extra_write", wd_a);
      else chk("tx_a_byte", wd_a, txq_a.pop_front());
    end
    if (fwr_b) begin
      writes_b++;
      if (txq_b.size() == 0) fail_now("tx_b_extra_write", wd_b);
      else chk("tx_b_byte", wd_b, txq_b.pop_front());
    end
    if (busy_a && full_a) chk("tx_a_write_while_full", fwr_a, 0);
    if (busy_b && full_b) chk("tx_b_write_while_full", fwr_b, 0);
    if (done_a) dones_a++;
    if (done_b) dones_b++;
    if (rxwv_a) begin
      if (rxq_a.size() == 0) fail_now("rx_a_extra_word", rxw_a);
      else chk("rx_a_word", rxw_a, rxq_a.pop_front());
    end
  end

  typedef struct {
    logic [15:0] word;
    int          stall;
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          lat;
  } tx_vec_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    int          gap;
    logic [15:0] exp;
  } rx_vec_t;

  task automatic tx_a(input tx_vec_t v);
    int n;
    int w0;
    logic seen, prev_busy;
    txq_a.push_back(v.b0);
    txq_a.push_back(v.b1);
    w0 = writes_a;
    @(posedge clk) #1;
    wr_a = 1'b1; win_a = v.word;
    @(posedge clk) #1;                 // request accepted on this edge
    wr_a = 1'b0; win_a = 16'($urandom);
    n = 1; seen = 1'b0; prev_busy = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (done_a) seen = 1'b1;
      else begin
        prev_busy = busy_a;
        @(posedge clk) #1;
        n++;
        full_a = (n >= 2) && (n < 2 + v.stall);
      end
    end
    full_a = 1'b0;
    chk("tx_done_seen", 32'(seen), 1);
    chk("tx_latency", n, v.lat);
    chk("tx_busy_before_done", 32'(prev_busy), 1);
    chk("tx_busy_at_done", 32'(busy_a), 0);
    chk("tx_write_count", writes_a - w0, 2);
    @(posedge clk) #1;
    @(negedge clk);
    chk("tx_done_one_cycle", 32'(done_a), 0);
  endtask

  task automatic rx_a(input rx_vec_t v);
    rxq_a.push_back(v.exp);
    @(posedge clk) #1;
    rxv_a = 1'b1; rxb_a = v.b0;
    @(posedge clk) #1;
    rxv_a = 1'b0; rxb_a = 8'($urandom);
    repeat (v.gap) @(posedge clk) #1;
    rxv_a = 1'b1; rxb_a = v.b1;
    @(posedge clk) #1;
    rxv_a = 1'b0;
    @(negedge clk);
    chk("rx_valid_after_last", 32'(rxwv_a), 1);
    chk("rx_word_value", rxw_a, v.exp);
    @(negedge clk);
    chk("rx_valid_one_cycle", 32'(rxwv_a), 0);
  endtask

  task automatic wait_done_b(input string name);
    int n;
    n = 0;
    while (!done_b && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done_b), 1);
  endtask

  tx_vec_t tv[6];
  rx_vec_t rv[4];

  initial begin
    int w0, d0;
    tv[0] = '{16'hA55A, 0, 8'h5A, 8'hA5, 3};
    tv[1] = '{16'hA55A, 3, 8'h5A, 8'hA5, 6};
    tv[2] = '{16'h0000, 0, 8'h00, 8'h00, 3};
    tv[3] = '{16'hFFFF, 1, 8'hFF, 8'hFF, 4};
    tv[4] = '{16'h1234, 2, 8'h34, 8'h12, 5};
    tv[5] = '{16'h8001, 0, 8'h01, 8'h80, 3};
    rv[0] = '{8'h34, 8'h12, 1, 16'h1234};
    rv[1] = '{8'h01, 8'hFF, 0, 16'hFF01};
    rv[2] = '{8'h00, 8'h00, 2, 16'h0000};
    rv[3] = '{8'hAB, 8'hCD, 3, 16'hCDAB};

    reset = 1'b1;
    wr_a = 0; win_a = '0; full_a = 0; rxb_a = '0; rxv_a = 0;
    wr_b = 0; win_b = '0; full_b = 0; rxb_b = '0; rxv_b = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_fifo_wr", 32'(fwr_a), 0);
    chk("rst_fifo_wdata", wd_a, 0);
    chk("rst_rx_word", rxw_a, 0);
    chk("rst_rx_word_valid", 32'(rxwv_a), 0);
    chk("rst_b_busy", 32'(busy_b), 0);
    chk("rst_b_fifo_wdata", wd_b, 0);

    for (int i = 0; i < 6; i++) tx_a(tv[i]);

    // Held request on the 4-byte MSB-first instance: exactly one send.
    txq_b.push_back(8'h11); txq_b.push_back(8'h22);
    txq_b.push_back(8'h33); txq_b.push_back(8'h44);
    w0 = writes_b; d0 = dones_b;
    @(posedge clk) #1;
    wr_b = 1'b1; win_b = 32'h11223344;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      win_b = $urandom;
    end
    wr_b = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold_write_count", writes_b - w0, 4);
    chk("hold_done_count", dones_b - d0, 1);
    chk("hold_busy", 32'(busy_b), 0);

    // Reset in the middle of a send: bytes AA and BB go out, then abandoned.
    txq_b.push_back(8'hAA); txq_b.push_back(8'hBB);
    d0 = dones_b;
    @(posedge clk) #1;
    wr_b = 1'b1; win_b = 32'hAABBCCDD;
    @(posedge clk) #1;
    wr_b = 1'b0;
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy_b), 0);
    chk("mid_rst_fifo_wr", 32'(fwr_b), 0);
    chk("mid_rst_done", 32'(done_b), 0);
    chk("mid_rst_wdata", wd_b, 0);
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", dones_b - d0, 0);
    txq_b.push_back(8'h11); txq_b.push_back(8'h22);
    txq_b.push_back(8'h33); txq_b.push_back(8'h44);
    w0 = writes_b;
    @(posedge clk) #1;
    wr_b = 1'b1; win_b = 32'h11223344;
    @(posedge clk) #1;
    wr_b = 1'b0;
    wait_done_b("resend_done_seen");
    chk("resend_write_count", writes_b - w0, 4);

    // RX packing
    for (int i = 0; i < 4; i++) rx_a(rv[i]);
    @(posedge clk) #1;
    rxv_a = 1'b1; rxb_a = 8'h77;
    @(posedge clk) #1;
    rxv_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("rx_partial_holds_word", rxw_a, 16'hCDAB);
    @(posedge clk) #1;
    reset = 1'b1;
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rx_reset_word", rxw_a, 0);

    // Back-to-back strobes: no gap between words.
    rxq_a.push_back(16'h0201);
    rxq_a.push_back(16'h0403);
    @(posedge clk) #1;
    for (int i = 1; i <= 4; i++) begin
      rxv_a = 1'b1; rxb_a = 8'(i);
      @(posedge clk) #1;
    end
    rxv_a = 1'b0;
    repeat (4) @(negedge clk);
    chk("rx_last_word", rxw_a, 16'h0403);

    chk("txq_a_drained", txq_a.size(), 0);
    chk("txq_b_drained", txq_b.size(), 0);
    chk("rxq_a_drained", rxq_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_word_serializer.md
# uart_word_serializer

Parametrised word-to-byte bridge between the datapath and the UART byte FIFOs. On the TX side it latches an `NBYTES*DBIT`-bit word and pushes it byte by byte into the transmit FIFO, honouring FIFO back-pressure and a selectable byte order. On the RX side it packs consecutive received bytes back into a word. It replaces the fixed 16-bit, two-byte splitter, which had no back-pressure, and adds the RX direction.

## Interface
Parameters:
- `DBIT`, 8, bits per UART byte.
- `NBYTES`, 2, bytes per word (must be ≥1); word width `W = NBYTES*DBIT`.
- `MSB_FIRST`, 0, byte order. 0 sends/receives the least significant byte first; 1 sends/receives the most significant byte first.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `wr_word` in 1: level request to send `word_in`; sampled in IDLE.
- `word_in` in W: word to transmit; latched when the request is accepted.
- `fifo_full` in 1: TX FIFO full flag.
- `fifo_wdata` out DBIT: byte presented to the TX FIFO.
- `fifo_wr` out 1: TX FIFO write strobe; one byte per cycle while high.
- `busy` out 1: high from request acceptance until the last byte is written.
- `done` out 1: one-cycle pulse after the last byte is written.
- `rx_byte` in DBIT: received byte from the RX path.
- `rx_valid` in 1: one-cycle strobe qualifying `rx_byte`.
- `rx_word` out W: last fully assembled word.
- `rx_word_valid` out 1: one-cycle pulse when `rx_word` updates.

## Operation
TX FSM states: IDLE, SEND, DONE, HOLD.
- IDLE → SEND when `wr_word=1`. On that edge, `word_in` is latched into a shift register and the byte index `tx_cnt` is cleared to 0.
- SEND:
  - `fifo_wr = (state==SEND) && !fifo_full`, combinational.
  - `fifo_wdata` is the current head byte of the shift register, combinational.
  - Head byte is `[DBIT-1:0]` when `MSB_FIRST=0`, or `[W-1:W-DBIT]` when `MSB_FIRST=1`.
  - On each edge with `fifo_wr=1`, the register shifts by DBIT toward the head and `tx_cnt` increments.
  - When the write with `tx_cnt==NBYTES-1` occurs, go to DONE.
  - While `fifo_full=1`, the block stalls: no shift, no count.
- DONE: `done=1` for exactly one cycle. Next state is HOLD if `wr_word=1`, else IDLE.
- HOLD: stay until `wr_word=0`, then IDLE. This means a held level request sends the word exactly once, as the legacy level protocol did.
- `busy = (state==SEND)`.
- `wr_word` and `word_in` changes during SEND, DONE or HOLD are ignored.
- `tx_cnt` width is `max(1, clog2(NBYTES))`. `tx_cnt` never wraps past `NBYTES-1`.

RX packer (runs independently of TX):
- Each `rx_valid` shifts `rx_byte` into an assembly register and increments `rx_cnt`.
- `MSB_FIRST=0`: the byte enters at the top and the register shifts right, so the first byte ends up as the LSB.
- `MSB_FIRST=1`: the byte enters at the bottom and the register shifts left.
- On the strobe with `rx_cnt==NBYTES-1`, the next edge:
  - copies the completed word to `rx_word`,
  - pulses `rx_word_valid` for 1 cycle,
  - returns `rx_cnt` to 0.
- `rx_word` holds its value between updates.

Reset (synchronous):
- State returns to IDLE; `tx_cnt`, `rx_cnt` and the shift/assembly registers are cleared to 0.
- Outputs after reset: `busy=0`, `done=0`, `fifo_wr=0`, `fifo_wdata=0`, `rx_word=0`, `rx_word_valid=0`.
- Reset mid-SEND abandons the word. Bytes already written stay in the FIFO, and no `done` is issued.
- Reset mid-assembly discards the partial RX bytes.

## Timing
- Request accepted at edge k, so SEND starts at cycle k+1.
- With no back-pressure, byte i is written at edge k+1+i. The last byte is at edge k+NBYTES, and `done` is high during cycle k+NBYTES+1.
- Minimum request-to-request interval is NBYTES+2 cycles: SEND×NBYTES, then DONE, then IDLE. Add +1 if passing through HOLD.
- Each cycle of `fifo_full=1` in SEND adds exactly one cycle of latency.
- `fifo_full` is used in the same cycle, so the block never writes a full FIFO.
- RX: `rx_word_valid` is high in the cycle after the final `rx_valid`. `rx_valid` on consecutive cycles is accepted every cycle, with no gap.
- `rx_valid` in the same cycle as a word completion counts as the last byte of that word, not the first byte of the next.

## Test plan
- Defaults, `word_in=16'hA55A`, `wr_word` high for 1 cycle, `fifo_full=0` → `fifo_wdata` 8'h5A then 8'hA5 on two consecutive `fifo_wr` cycles. Then `done` pulses once and `busy` falls with it.
- Same stimulus with `fifo_full=1` for 3 cycles after the first byte → 8'hA5 is written only after `fifo_full` drops, `done` arrives 3 cycles later, and no write occurs while full.
- `NBYTES=4`, `MSB_FIRST=1`, `word_in=32'h11223344` → bytes 8'h11, 8'h22, 8'h33, 8'h44 in that order. `wr_word` held high for 20 cycles → exactly 4 writes and a single `done`.
- RX, defaults: `rx_valid` with 8'h34, then 8'h12 two cycles later → `rx_word=16'h1234` and `rx_word_valid` for 1 cycle. A further single byte leaves `rx_word` unchanged.
- `reset` asserted after the first of 4 bytes in SEND → next cycle IDLE, `busy=0`, `fifo_wr=0`, no `done`. A new request then sends all 4 bytes from byte 0.
- Back-to-back RX: 4 `rx_valid` strobes on consecutive cycles (8'h01, 8'h02, 8'h03, 8'h04), defaults → two `rx_word_valid` pulses with 16'h0201 and then 16'h0403.
